// File: rtl/inst_mem_responder.sv
// Instruction-fetch responder with a byte-serial program load port.
// Fetches are served from IDLE with one cycle of latency; loads assemble big-endian words.
module inst_mem_responder #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_ce_i,
  input  logic [31:0]       rom_addr_i,
  output logic [31:0]       rom_data_o,
  output logic              rom_ready_o,
  input  logic              ld_start_i,
  input  logic [ADDR_W-1:0] ld_base_i,
  input  logic [ADDR_W:0]   ld_count_i,
  input  logic              ld_valid_i,
  input  logic [7:0]        ld_byte_i,
  output logic              ld_ready_o,
  output logic              ld_done_o
);

  localparam int unsigned Depth = 1 << ADDR_W;

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_words_left;
  logic [1:0]        r_byte_cnt;
  logic [23:0]       r_buf;
  logic [31:0]       r_rom_data;
  logic              r_rom_ready;
  logic [31:0]       r_mem [Depth];

  logic              w_wr;
  logic [31:0]       w_word;
  logic [ADDR_W-1:0] w_rd_idx;
  logic              w_oor;
  logic              w_unused_addr_lsb;

  assign w_wr              = (r_state == StLoad) && ld_valid_i && (r_byte_cnt == 2'd3);
  assign w_word            = {r_buf, ld_byte_i};
  assign w_rd_idx          = rom_addr_i[ADDR_W+1:2];
  assign w_oor             = |rom_addr_i[31:ADDR_W+2];
  assign w_unused_addr_lsb = ^rom_addr_i[1:0];

  assign rom_data_o  = r_rom_data;
  assign rom_ready_o = r_rom_ready;
  assign ld_ready_o  = (r_state == StLoad);
  assign ld_done_o   = (r_state == StDone);

  // Program memory is deliberately left out of reset so loaded code survives it.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_ptr] <= w_word;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= StIdle;
      r_ptr        <= '0;
      r_words_left <= '0;
      r_byte_cnt   <= '0;
      r_buf        <= '0;
      r_rom_data   <= '0;
      r_rom_ready  <= 1'b0;
    end else begin
      r_rom_data  <= '0;
      r_rom_ready <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (rom_ce_i) begin
            r_rom_ready <= 1'b1;
            r_rom_data  <= w_oor ? 32'd0 : r_mem[w_rd_idx];
          end
          if (ld_start_i) begin
            r_ptr        <= ld_base_i;
            r_words_left <= ld_count_i;
            r_byte_cnt   <= '0;
            r_buf        <= '0;
            r_state      <= (ld_count_i == '0) ? StDone : StLoad;
          end
        end
        StLoad: begin
          if (ld_valid_i) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_ptr        <= r_ptr + ADDR_W'(1);
              r_words_left <= r_words_left - (ADDR_W + 1)'(1);
              if (r_words_left == (ADDR_W + 1)'(1)) begin
                r_state <= StDone;
              end
            end else begin
              r_buf <= {r_buf[15:0], ld_byte_i};
            end
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: doc/inst_mem_responder.md
# inst_mem_responder

Responder side of the core's instruction-fetch port: holds program memory, answers fetches driven by the core's `rom_ce_o` and `rom_addr_o` outputs, and returns words on the core's `rom_data_i` input. A byte-serial load port fills the memory with a program before or between runs, assembling big-endian 32-bit words. Sits beside `openmips` at SoC top level, replacing a plain combinational ROM.

## Interface
- `ADDR_W`, default 10: word-address width; depth = 2^ADDR_W words.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `rom_ce_i`  in  1  fetch enable from core.
- `rom_addr_i`  in  32  byte address from core.
- `rom_data_o`  out  32  fetched instruction to core.
- `rom_ready_o`  out  1  `rom_data_o` valid this cycle.
- `ld_start_i`  in  1  begin a load (sampled in IDLE only).
- `ld_base_i`  in  ADDR_W  first word address of the load.
- `ld_count_i`  in  ADDR_W+1  number of words to load.
- `ld_valid_i`  in  1  `ld_byte_i` valid.
- `ld_byte_i`  in  8  program byte.
- `ld_ready_o`  out  1  block accepts a byte.
- `ld_done_o`  out  1  one-cycle load-complete pulse.

## Operation
- FSM states: IDLE, LOAD, DONE.
- IDLE: `ld_start_i`=1 latches `ld_base_i` into the write pointer and `ld_count_i` into words_left, and clears the byte counter.
  - words_left≠0 → LOAD.
  - `ld_count_i`=0 → DONE directly.
- LOAD: `ld_ready_o`=1. A byte transfers when `ld_valid_i`&`ld_ready_o`.
  - Byte counter 0..3. Byte 0 goes to word[31:24], byte 1 to [23:16], byte 2 to [15:8], byte 3 to [7:0].
  - On byte 3 the assembled word is written to mem[ptr] at that edge, ptr increments modulo 2^ADDR_W (wraps), and words_left decrements.
  - words_left reaching 0 → DONE.
  - `ld_start_i` is ignored in LOAD.
- DONE: `ld_done_o`=1 for exactly one cycle, then IDLE.
- Fetch, IDLE only: when `rom_ce_i`=1 is sampled at an edge, the read word index is `rom_addr_i[ADDR_W+1:2]`.
  - `rom_addr_i[1:0]` is ignored.
  - If `rom_addr_i[31:ADDR_W+2]`≠0, the fetch is out of range: `rom_data_o`=0 and `rom_ready_o`=1.
- Fetch when `rom_ce_i`=0 at the edge, or in LOAD/DONE: next cycle `rom_data_o`=0 and `rom_ready_o`=0. Fetches are blocked while a load is in progress.
- `ld_count_i` > depth wraps and overwrites earlier words of the same load.
- Memory contents are not cleared by reset. Uninitialised words read as X in simulation.
- Reset mid-load: FSM → IDLE, counters and partial-word buffer cleared. Words already written are retained; the partial word is discarded.

## Timing
- Reset values: `rom_data_o`=0, `rom_ready_o`=0, `ld_ready_o`=0, `ld_done_o`=0, FSM=IDLE, ptr/words_left/byte counter=0.
- `rom_data_o` and `rom_ready_o` are registered. Fetch latency is 1 cycle: a fetch sampled at edge N produces valid `rom_data_o` and `rom_ready_o` during cycle N→N+1.
- `ld_ready_o` = (state==LOAD) and `ld_done_o` = (state==DONE), both decoded from the registered state.
- The last byte accepted at edge N puts the FSM in DONE after N, so `ld_done_o` is high for cycle N→N+1 and the FSM is in IDLE after N+1.
- The first fetch able to observe new contents is the one sampled at edge N+2 (data valid at edge N+3).
- `ld_start_i` sampled at edge S: `ld_ready_o` is high from S onward.
- With `ld_valid_i` held high, one word is written every 4 cycles. Gaps in `ld_valid_i` stall the byte counter without losing state.

## Test plan
- Reset: assert `rst`=0 mid-operation → all outputs 0 immediately; release, then fetch addr 0 with `rom_ce_i`=0 → `rom_ready_o`=0 and `rom_data_o`=0.
- Load with base 0, count 2, bytes 34 01 11 00 34 02 00 20 → `ld_done_o` is a single one-cycle pulse; fetch 0x0 → 0x34011100; fetch 0x4 → 0x34020020; fetch 0x6 → 0x34020020; each with `rom_ready_o`=1 one cycle after the request.
- Same load with `ld_valid_i` randomly deasserted, plus a fetch issued during LOAD → identical memory contents; the blocked fetch returns `rom_ready_o`=0 and `rom_data_o`=0.
- Load 2 words at base 4, pull `rst` low after 6 bytes, then release → mem[4] holds the new word, mem[5] holds its old value, FSM=IDLE, `ld_ready_o`=0.
- `ADDR_W`=4, base 15, count 2 → writes mem[15] then mem[0]. Separately, `ld_count_i`=0 → `ld_done_o` pulse on the cycle after start with no writes.
- Fetch 0x0000_0040 with `ADDR_W`=4 (out of range) → `rom_data_o`=0 and `rom_ready_o`=1.
